// File: rtl/spi_wrapper_master_if.sv
// Command/response and serial-link signals of the SPI wrapper master.
// master: the wrapper itself; slave: the command source plus the slave wrapper.
interface spi_wrapper_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic       MOSI;
  logic       ss_n;
  logic       MISO;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_type, cmd_data, MISO,
    output cmd_ready, MOSI, ss_n, rd_valid, rd_data, busy
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_data, MISO,
    input  cmd_ready, MOSI, ss_n, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/spi_wrapper_master.sv
// Serialises one {type,data} command per frame to the SPI slave wrapper and,
// for read-data commands, shifts a byte back in after a turnaround cycle.
module spi_wrapper_master #(
  parameter int GAP_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_wrapper_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, FRAME, TURN, RECV, GAP} state_t;

  state_t     state;
  logic [4:0] cnt;
  logic [3:0] gap_cnt;
  logic [9:0] tx_sh;
  logic [7:0] rx_sh;
  logic       is_rd;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 5'd0;
      gap_cnt       <= 4'd0;
      tx_sh         <= 10'd0;
      rx_sh         <= 8'd0;
      is_rd         <= 1'b0;
      bus.ss_n      <= 1'b1;
      bus.MOSI      <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= 8'h00;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
    end else begin
      bus.rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            state         <= FRAME;
            cnt           <= 5'd0;
            tx_sh         <= {bus.cmd_type, bus.cmd_data};
            is_rd         <= &bus.cmd_type;
            bus.ss_n      <= 1'b0;
            bus.MOSI      <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
          end
        end
        FRAME: begin
          cnt <= cnt + 5'd1;
          // cycle 1 repeats type[1] as the r/w flag, so the shifter only
          // starts advancing from cycle 2 onwards
          if (cnt == 5'd0) begin
            bus.MOSI <= tx_sh[9];
          end else if (cnt <= 5'd10) begin
            bus.MOSI <= tx_sh[9];
            tx_sh    <= {tx_sh[8:0], 1'b0};
          end else begin
            bus.MOSI <= 1'b0;
            if (is_rd) begin
              state <= TURN;
            end else begin
              state    <= GAP;
              gap_cnt  <= 4'd0;
              bus.ss_n <= 1'b1;
            end
          end
        end
        TURN: begin
          cnt   <= cnt + 5'd1;
          state <= RECV;
        end
        RECV: begin
          cnt   <= cnt + 5'd1;
          rx_sh <= {rx_sh[6:0], bus.MISO};
          if (cnt == 5'd20) begin
            bus.rd_data  <= {rx_sh[6:0], bus.MISO};
            bus.rd_valid <= 1'b1;
            bus.ss_n     <= 1'b1;
            state        <= GAP;
            gap_cnt      <= 4'd0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.ss_n      <= 1'b1;
          bus.MOSI      <= 1'b0;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_wrapper_master.sv
// Randomised bench for spi_wrapper_master with a per-cycle frame model and a
// behavioural slave wrapper holding a 256-byte RAM.
module tb_spi_wrapper_master;
  localparam int GAP = 3;
  localparam int NC  = 26;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_wrapper_master_if bus();

  logic tb_miso = 1'b0;
  logic slave_en = 1'b0;
  logic s_miso;
  assign bus.MISO = slave_en ? s_miso : tb_miso;

  spi_wrapper_master #(.GAP_CYCLES(GAP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  exp_rd = 8'h00;
  logic [12:0] obs [NC];
  localparam logic [12:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};

  // ---------------- slave wrapper model with RAM ----------------
  logic [4:0] s_cnt;
  logic [9:0] s_sh;
  logic [7:0] s_wa, s_ra;
  logic [7:0] ram [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt <= 5'd0;
      s_sh  <= 10'd0;
    end else if (!bus.ss_n) begin
      s_cnt <= s_cnt + 5'd1;
      if (s_cnt >= 5'd2 && s_cnt <= 5'd11) s_sh <= {s_sh[8:0], bus.MOSI};
    end else if (s_cnt != 5'd0) begin
      s_cnt <= 5'd0;
      case (s_sh[9:8])
        2'b00:   s_wa <= s_sh[7:0];
        2'b01:   ram[s_wa] <= s_sh[7:0];
        2'b10:   s_ra <= s_sh[7:0];
        default: ;
      endcase
    end
  end

  always @(negedge clk)
    s_miso <= (s_cnt >= 5'd13 && s_cnt <= 5'd20 && s_sh[9:8] == 2'b11)
              ? ram[s_ra][20 - int'(s_cnt)] : 1'b0;

  // ---------------- reference model ----------------
  // {ss_n, MOSI, rd_valid, cmd_ready, busy, rd_data} at frame cycle k
  function automatic logic [12:0] model(input logic [1:0] t, input logic [7:0] d,
                                       input logic [7:0] m, input logic [7:0] prev,
                                       input int k);
    logic [9:0] w;
    int len;
    logic mosi, rdy;
    w   = {t, d};
    len = (t == 2'b11) ? 21 : 12;
    mosi = 1'b0;
    if (k == 1) mosi = t[1];
    else if (k >= 2 && k <= 11) mosi = w[11 - k];
    rdy = (k >= len + GAP);
    return {(k >= len), mosi, (t == 2'b11 && k == len), rdy, !rdy,
            (t == 2'b11 && k >= len) ? m : prev};
  endfunction

  function automatic logic [12:0] snap();
    return {bus.ss_n, bus.MOSI, bus.rd_valid, bus.cmd_ready, bus.busy, bus.rd_data};
  endfunction

  // Issues one command from IDLE and records NC cycles of outputs into obs.
  task automatic do_frame(input logic [1:0] t, input logic [7:0] d,
                          input logic [7:0] m, input bit toggle);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_type = t; bus.cmd_data = d;
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      obs[k] = snap();
      bus.cmd_valid = (toggle && k < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (toggle) begin
        bus.cmd_type = 2'($urandom);
        bus.cmd_data = 8'($urandom);
      end
      tb_miso = (k >= 13 && k <= 20) ? m[20 - k] : 1'($urandom);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [12:0] o;
    bus.cmd_valid = 1'b0; bus.cmd_type = 2'b00; bus.cmd_data = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    o = snap(); n_vec++;
    if (o !== RST_VEC) begin n_err++; $display("FAIL reset_hold got %b want %b", o, RST_VEC); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    o = snap(); n_vec++;
    if (o !== RST_VEC) begin n_err++; $display("FAIL reset_idle got %b want %b", o, RST_VEC); end
    exp_rd = 8'h00;
  endtask

  task automatic test_write_addr();
    logic [11:0] seq;
    logic [12:0] e;
    seq = 12'b0000_1010_0101;
    do_frame(2'b00, 8'hA5, 8'($urandom), 1'b0);
    for (int k = 0; k < NC; k++) begin
      e = model(2'b00, 8'hA5, 8'h00, exp_rd, k); n_vec++;
      if (obs[k] !== e) begin n_err++; $display("FAIL wr_addr cyc%0d got %b want %b", k, obs[k], e); end
    end
    for (int k = 0; k < 12; k++) begin
      n_vec++;
      if (obs[k][11] !== seq[11 - k]) begin
        n_err++; $display("FAIL wr_addr_mosi cyc%0d got %b want %b", k, obs[k][11], seq[11 - k]);
      end
    end
  endtask

  task automatic test_read_data();
    logic [12:0] e;
    do_frame(2'b11, 8'h00, 8'h3C, 1'b0);
    for (int k = 0; k < NC; k++) begin
      e = model(2'b11, 8'h00, 8'h3C, exp_rd, k); n_vec++;
      if (obs[k] !== e) begin n_err++; $display("FAIL rd_data cyc%0d got %b want %b", k, obs[k], e); end
    end
    exp_rd = 8'h3C;
    n_vec++;
    if (obs[21][10] !== 1'b1 || obs[20][10] !== 1'b0 || obs[22][10] !== 1'b0 || bus.rd_data !== 8'h3C) begin
      n_err++; $display("FAIL rd_data_pulse got v=%b%b%b d=%h want v=010 d=3c",
                        obs[20][10], obs[21][10], obs[22][10], bus.rd_data);
    end
  endtask

  task automatic test_ignored_inputs();
    logic [1:0] t; logic [7:0] d, m; logic [12:0] e;
    for (int i = 0; i < 4; i++) begin
      t = 2'(i); d = 8'($urandom); m = 8'($urandom);
      do_frame(t, d, m, 1'b1);
      for (int k = 0; k < NC; k++) begin
        e = model(t, d, m, exp_rd, k); n_vec++;
        if (obs[k] !== e) begin n_err++; $display("FAIL ignored t%0d cyc%0d got %b want %b", t, k, obs[k], e); end
      end
      if (t == 2'b11) exp_rd = m;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2, m; logic [12:0] o, e; int hi;
    d1 = 8'($urandom); d2 = 8'($urandom); m = 8'($urandom); hi = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_type = 2'b10; bus.cmd_data = d1;
    for (int c = 0; c < 16 + NC; c++) begin
      @(negedge clk);
      o = snap();
      e = (c < 16) ? model(2'b10, d1, m, exp_rd, c) : model(2'b11, d2, m, exp_rd, c - 16);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL b2b cyc%0d got %b want %b", c, o, e); end
      if (c >= 12 && c < 16 && o[12]) hi++;
      if (c == 0) begin bus.cmd_type = 2'b11; bus.cmd_data = d2; end
      if (c == 16) bus.cmd_valid = 1'b0;
      tb_miso = (c - 16 >= 13 && c - 16 <= 20) ? m[36 - c] : 1'($urandom);
    end
    exp_rd = m;
    n_vec++;
    if (hi !== GAP + 1) begin n_err++; $display("FAIL b2b_gap got %0d want %0d", hi, GAP + 1); end
  endtask

  task automatic test_random();
    logic [1:0] t; logic [7:0] d, m; logic [12:0] e; bit tg;
    for (int i = 0; i < 16; i++) begin
      t = 2'($urandom); d = 8'($urandom); m = 8'($urandom); tg = 1'($urandom);
      do_frame(t, d, m, tg);
      for (int k = 0; k < NC; k++) begin
        e = model(t, d, m, exp_rd, k); n_vec++;
        if (obs[k] !== e) begin n_err++; $display("FAIL random%0d cyc%0d got %b want %b", i, k, obs[k], e); end
      end
      if (t == 2'b11) exp_rd = m;
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d, dn; logic [12:0] o, e;
    d = 8'($urandom); dn = 8'($urandom);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_type = 2'b11; bus.cmd_data = d;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      tb_miso = 1'($urandom);
    end
    rst_n = 1'b0;
    #1;
    o = snap(); n_vec++;
    if (o !== RST_VEC) begin n_err++; $display("FAIL midrst_async got %b want %b", o, RST_VEC); end
    exp_rd = 8'h00;
    repeat (2) begin
      @(negedge clk);
      o = snap(); n_vec++;
      if (o !== RST_VEC) begin n_err++; $display("FAIL midrst_hold got %b want %b", o, RST_VEC); end
    end
    rst_n = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_type = 2'b00; bus.cmd_data = dn;
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      o = snap();
      bus.cmd_valid = 1'b0;
      e = model(2'b00, dn, 8'h00, exp_rd, k); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL midrst_restart cyc%0d got %b want %b", k, o, e); end
    end
  endtask

  task automatic test_end_to_end();
    logic [7:0] a, d;
    slave_en = 1'b1;
    do_frame(2'b00, 8'h12, 8'h00, 1'b0);
    do_frame(2'b01, 8'h7E, 8'h00, 1'b0);
    do_frame(2'b10, 8'h12, 8'h00, 1'b0);
    do_frame(2'b11, 8'($urandom), 8'h00, 1'b0);
    n_vec++;
    if (obs[21][10] !== 1'b1 || bus.rd_data !== 8'h7E) begin
      n_err++; $display("FAIL e2e_fixed got v=%b d=%h want v=1 d=7e", obs[21][10], bus.rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom); d = 8'($urandom);
      do_frame(2'b00, a, 8'h00, 1'b0);
      do_frame(2'b01, d, 8'h00, 1'b0);
      do_frame(2'b10, a, 8'h00, 1'b0);
      do_frame(2'b11, 8'($urandom), 8'h00, 1'b0);
      n_vec++;
      if (obs[21][10] !== 1'b1 || bus.rd_data !== d) begin
        n_err++; $display("FAIL e2e_rand%0d got v=%b d=%h want v=1 d=%h", i, obs[21][10], bus.rd_data, d);
      end
    end
    slave_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_read_data();
    test_ignored_inputs();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    test_end_to_end();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_wrapper_master.md
SPI_WRAPPER_MASTER -- requirements
Module: spi_wrapper_master

Interface
REQ-001 The block SHALL have one parameter: GAP_CYCLES, default 3, the minimum number of ss_n-high cycles between frames (legal range 1-15).
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  input  1  single clock; all outputs registered on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command.
- cmd_type  input  2  00 write-address, 01 write-data, 10 read-address, 11 read-data.
- cmd_data  input  8  address or data payload; ignored content for 11, but still shifted out.
- MOSI  output  1  serial data to the slave wrapper.
- ss_n  output  1  active-low slave select.
- MISO  input  1  serial data from the slave wrapper.
- rd_valid  output  1  one-cycle pulse; rd_data is valid.
- rd_data  output  8  byte received on a read-data frame.
- busy  output  1  high in every state other than IDLE.

Function
REQ-003 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; {cmd_type, cmd_data} are latched at that edge.
REQ-004 cmd_ready SHALL equal 1 only in state IDLE; input changes while cmd_ready=0 SHALL be ignored.
REQ-005 The FSM states SHALL be IDLE, FRAME, TURN, RECV and GAP.
REQ-006 Frame cycle numbering SHALL be: cycle 0 = the first cycle with ss_n=0, which is the cycle after acceptance.
REQ-007 In FRAME:
- cycle 0: MOSI=0 (slave command-check cycle).
- cycle 1: MOSI=cmd_type[1] (0 = write, 1 = read).
- cycles 2-11: MOSI = {cmd_type, cmd_data}, MSB first.
REQ-008 For cmd_type 00, 01 or 10, ss_n SHALL rise at cycle 12 and the FSM SHALL enter GAP.
REQ-009 For cmd_type 11:
- cycle 12 (TURN): ss_n=0, MOSI=0.
- cycles 13-20 (RECV): MISO sampled at the end of each cycle, MSB first, into a shift register; MOSI=0.
- cycle 21: ss_n=1; rd_data updated and rd_valid=1 for exactly this one cycle; FSM enters GAP.
REQ-010 A 5-bit counter SHALL track the frame cycle; it SHALL clear on entry to FRAME and never wrap within a frame.
REQ-011 GAP SHALL hold ss_n=1 and MOSI=0 for exactly GAP_CYCLES cycles, then return to IDLE.
REQ-012 Back-to-back timing SHALL be: with cmd_valid held high, the next ss_n falling edge occurs GAP_CYCLES+1 cycles after the previous rising edge (GAP_CYCLES cycles in GAP plus one IDLE acceptance cycle).
REQ-013 rd_data SHALL hold its last value until the next read-data frame completes.
REQ-014 rd_valid SHALL never assert for command types 00, 01 or 10.
REQ-015 MISO SHALL be ignored outside RECV.
REQ-016 In IDLE, ss_n=1 and MOSI=0.

Reset
REQ-017 On rst_n=0, immediately and asynchronously:
- state=IDLE; ss_n=1; MOSI=0; rd_valid=0; rd_data=8'h00; busy=0; counter cleared.
- cmd_ready=1 (state is IDLE).
REQ-018 Reset asserted mid-frame SHALL abort the frame with no rd_valid pulse.
REQ-019 After reset, a command SHALL be acceptable on the first rising edge after rst_n deasserts; no GAP is inserted.

Verification
REQ-020 Write-address: accept cmd_type=00, cmd_data=8'hA5 -> ss_n low cycles 0-11; MOSI sequence 0,0,0,0,1,0,1,0,0,1,0,1; ss_n high at cycle 12; rd_valid stays 0.
REQ-021 Read-data: accept cmd_type=11, cmd_data=8'h00; drive MISO=8'h3C MSB first over cycles 13-20 -> MOSI cycles 1-3 = 1,1,1; ss_n high at cycle 21; rd_valid=1 for one cycle with rd_data=8'h3C.
REQ-022 Back-to-back: cmd_valid held high with a 10 then 11 command sequence, GAP_CYCLES=3 -> exactly 3 ss_n-high cycles in GAP plus 1 IDLE cycle between frames; cmd_ready=0 throughout frames and GAP.
REQ-023 Reset mid-read: assert rst_n=0 at cycle 16 of a read-data frame -> ss_n=1 and MOSI=0 immediately; no rd_valid; rd_data=8'h00; a new command is accepted on the first edge after release.
REQ-024 End-to-end against the slave wrapper with RAM: write-address 8'h12, write-data 8'h7E, read-address 8'h12, read-data -> rd_data=8'h7E.
REQ-025 Ignored inputs: toggling cmd_type and cmd_data mid-frame -> serial stream unchanged from the latched command.
